// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1 serializer (LSB first) fed by a ready/valid source.
// Optional even parity bit between data bit 7 and stop when UART_TX_PARITY_EN is defined.
//
// state | meaning
// IDLE  | line high, ready high, waiting for a character
// SEND  | shifting the frame out, one bit per SYMBOL_EDGE_TIME cycles
module uart_transmitter #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CLK_CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [CLK_CNT_W-1:0] CLK_CNT_MAX = CLK_CNT_W'(SYMBOL_EDGE_TIME - 1);

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam int BIT_CNT_W  = 5;
`else
  localparam int FRAME_BITS = 10;
  localparam int BIT_CNT_W  = 4;
`endif

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state;
  logic [FRAME_BITS-2:0]   shift_reg;   // bits still to go; the current bit sits in serial_out
  logic [CLK_CNT_W-1:0]    clk_cnt;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic [FRAME_BITS-1:0]   frame_load;

`ifdef UART_TX_PARITY_EN
  assign frame_load = {1'b1, ^data_in, data_in, 1'b0};
`else
  assign frame_load = {1'b1, data_in, 1'b0};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shift_reg     <= '1;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      data_in_ready <= 1'b1;
      serial_out    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          data_in_ready <= 1'b1;
          serial_out    <= 1'b1;
          if (data_in_valid && data_in_ready) begin
            state         <= SEND;
            shift_reg     <= frame_load[FRAME_BITS-1:1];
            clk_cnt       <= '0;
            bit_cnt       <= '0;
            data_in_ready <= 1'b0;
            serial_out    <= frame_load[0];
          end
        end
        SEND: begin
          if (clk_cnt == CLK_CNT_MAX) begin
            clk_cnt   <= '0;
            shift_reg <= {1'b1, shift_reg[FRAME_BITS-2:1]};
            bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              state         <= IDLE;
              data_in_ready <= 1'b1;
              serial_out    <= 1'b1;
            end else begin
              serial_out <= shift_reg[0];
            end
          end else begin
            clk_cnt <= clk_cnt + CLK_CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter (CLOCK_FREQ=1000, BAUD_RATE=100 -> 10 cycles/bit).
// Define UART_TX_PARITY_EN for both bench and RTL to exercise the parity build.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int SET = 10;
  localparam int F   = NB * SET;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic line_q [0:255];
  logic rdy_q  [0:255];

  always #5 clk = ~clk;

  uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out)
  );

  // Expected frame, index = bit time; parity value is supplied by hand.
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
    return {1'b1, p, d, 1'b0};
`else
    return {p, 1'b1, d, 1'b0};
`endif
  endfunction

  // Records line and ready once per cycle at negedge; optionally drives valid.
  task automatic capture(input int n, input int on_at, input logic [7:0] on_data, input int off_at);
    for (int i = 0; i < n; i++) begin
      line_q[i] = serial_out;
      rdy_q[i]  = data_in_ready;
      if (i == on_at) begin
        data_in_valid = 1'b1;
        data_in       = on_data;
      end
      if (i == off_at) data_in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (serial_out !== 1'b1 || data_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_out: got line=%b ready=%b want line=1 ready=1", serial_out, data_in_ready);
    end
    capture(50, -1, 8'h00, -1);
    for (int i = 0; i < 50; i++) begin
      n_cmp++;
      if (line_q[i] !== 1'b1 || rdy_q[i] !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_idle[%0d]: got line=%b ready=%b want 1 1", i, line_q[i], rdy_q[i]);
      end
    end
  endtask

  task automatic test_single;
    logic [10:0] ef;
    ef = mk_frame(8'hA5, 1'b0);
    n_cmp++;
    if (data_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_ready_pre: got %b want 1", data_in_ready);
    end
    data_in = 8'hA5;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    data_in = 8'h00;
    capture(F + 1, -1, 8'h00, -1);
    for (int i = 0; i < F; i++) begin
      n_cmp++;
      if (line_q[i] !== ef[i/SET] || rdy_q[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL single[%0d]: got line=%b ready=%b want line=%b ready=0", i, line_q[i], rdy_q[i], ef[i/SET]);
      end
    end
    n_cmp++;
    if (line_q[F] !== 1'b1 || rdy_q[F] !== 1'b1) begin
      n_bad++;
      $display("FAIL single_end: got line=%b ready=%b want 1 1", line_q[F], rdy_q[F]);
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] e1, e2;
    logic        el, er;
    e1 = mk_frame(8'h00, 1'b0);
    e2 = mk_frame(8'hFF, 1'b0);
    data_in = 8'h00;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in = 8'hFF;
    capture(2*F + 2, -1, 8'h00, F + 1);
    for (int i = 0; i < 2*F + 2; i++) begin
      if (i < F) begin
        el = e1[i/SET]; er = 1'b0;
      end else if (i == F) begin
        el = 1'b1; er = 1'b1;
      end else if (i <= 2*F) begin
        el = e2[(i-F-1)/SET]; er = 1'b0;
      end else begin
        el = 1'b1; er = 1'b1;
      end
      n_cmp++;
      if (line_q[i] !== el || rdy_q[i] !== er) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got line=%b ready=%b want line=%b ready=%b", i, line_q[i], rdy_q[i], el, er);
      end
    end
  endtask

  task automatic test_ignore_mid;
    logic [10:0] ef;
    ef = mk_frame(8'h41, 1'b0);
    data_in = 8'h41;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    capture(F + 21, 40, 8'h3C, 41);
    for (int i = 0; i < F + 21; i++) begin
      n_cmp++;
      if (i < F) begin
        if (line_q[i] !== ef[i/SET] || rdy_q[i] !== 1'b0) begin
          n_bad++;
          $display("FAIL ignore[%0d]: got line=%b ready=%b want line=%b ready=0", i, line_q[i], rdy_q[i], ef[i/SET]);
        end
      end else if (line_q[i] !== 1'b1 || rdy_q[i] !== 1'b1) begin
        n_bad++;
        $display("FAIL ignore_idle[%0d]: got line=%b ready=%b want 1 1", i, line_q[i], rdy_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [10:0] ef;
    ef = mk_frame(8'h55, 1'b0);
    data_in = 8'h00;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    repeat (35) @(negedge clk);
    n_cmp++;
    if (serial_out !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_pre: got line=%b want 0", serial_out);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (serial_out !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_line: got %b want 1", serial_out);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (serial_out !== 1'b1 || data_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_after: got line=%b ready=%b want 1 1", serial_out, data_in_ready);
    end
    data_in = 8'h55;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    capture(F + 1, -1, 8'h00, -1);
    for (int i = 0; i < F; i++) begin
      n_cmp++;
      if (line_q[i] !== ef[i/SET] || rdy_q[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL rstmid_55[%0d]: got line=%b ready=%b want line=%b ready=0", i, line_q[i], rdy_q[i], ef[i/SET]);
      end
    end
    n_cmp++;
    if (line_q[F] !== 1'b1 || rdy_q[F] !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_55_end: got line=%b ready=%b want 1 1", line_q[F], rdy_q[F]);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [10:0] ef;
    logic [7:0]  d;
    for (int k = 0; k < 2; k++) begin
      d  = (k == 0) ? 8'h07 : 8'h03;
      ef = mk_frame(d, (k == 0) ? 1'b1 : 1'b0);
      data_in = d;
      data_in_valid = 1'b1;
      @(negedge clk);
      data_in_valid = 1'b0;
      capture(F + 1, -1, 8'h00, -1);
      for (int i = 0; i < F; i++) begin
        n_cmp++;
        if (line_q[i] !== ef[i/SET] || rdy_q[i] !== 1'b0) begin
          n_bad++;
          $display("FAIL parity_%h[%0d]: got line=%b ready=%b want line=%b ready=0", d, i, line_q[i], rdy_q[i], ef[i/SET]);
        end
      end
      n_cmp++;
      if (line_q[F] !== 1'b1 || rdy_q[F] !== 1'b1) begin
        n_bad++;
        $display("FAIL parity_%h_end: got line=%b ready=%b want 1 1", d, line_q[F], rdy_q[F]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_mid();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
